// File: rtl/elevator_pkg.sv
// Shared types for the elevator car controller and the twin-car arbiter.
package elevator_pkg;

    localparam int MAX_FLOORS = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/door_timer.sv
// Door-open countdown: load sets DOOR_TICKS, each tick decrements; expire flags the tick at count 1.
module door_timer #(
    parameter int DOOR_TICKS = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic tick_i,
    output logic expire_o
);

    localparam int CW = $clog2(DOOR_TICKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(DOOR_TICKS);
        end else if (tick_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign expire_o = tick_i && (cnt_q == CW'(1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Single elevator car: latches floor calls, travels one floor per tick, holds door for DOOR_TICKS.
// Optional ELEVATOR_ESTOP_EN adds estop_i which freezes the car while still latching calls.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int DOOR_TICKS = 3
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          tick_i,
    input  logic [NUM_FLOORS-1:0]         req_i,
`ifdef ELEVATOR_ESTOP_EN
    input  logic                          estop_i,
`endif
    output logic [$clog2(NUM_FLOORS)-1:0] floor_o,
    output logic                          moving_up_o,
    output logic                          moving_down_o,
    output logic                          door_open_o,
    output logic [NUM_FLOORS-1:0]         pending_o,
    output logic                          arrived_o
);

    localparam int FW = $clog2(NUM_FLOORS);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

    state_t                state_q, state_d;
    dir_t                  dir_q, dir_d;
    logic [FW-1:0]         floor_q, floor_d, nf;
    logic [NUM_FLOORS-1:0] pending_q, pending_d, pend_nx;
    logic                  up_q, up_d, dn_q, dn_d, door_q, door_d, arrived_q, arrived_d;
    logic                  tmr_load, tmr_tick, tmr_expire;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [FW-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) any_above = any_above | v[i];
        end
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [FW-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) any_below = any_below | v[i];
        end
    endfunction

    door_timer #(.DOOR_TICKS(DOOR_TICKS)) u_door_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (tmr_load),
        .tick_i   (tmr_tick),
        .expire_o (tmr_expire)
    );

    always_comb begin
        pend_nx   = pending_q | req_i;
        state_d   = state_q;
        dir_d     = dir_q;
        floor_d   = floor_q;
        pending_d = pend_nx;
        nf        = floor_q;
        tmr_load  = 1'b0;
        tmr_tick  = tick_i;
        arrived_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_nx[floor_q]) begin
                    state_d            = DOOR_OPEN;
                    pending_d[floor_q] = 1'b0;
                    tmr_load           = 1'b1;
                end else if (dir_q == DIR_UP && any_above(pend_nx, floor_q)) begin
                    state_d = MOVE_UP;
                end else if (dir_q == DIR_DOWN && any_below(pend_nx, floor_q)) begin
                    state_d = MOVE_DOWN;
                end else if (any_above(pend_nx, floor_q)) begin
                    state_d = MOVE_UP;
                    dir_d   = DIR_UP;
                end else if (any_below(pend_nx, floor_q)) begin
                    state_d = MOVE_DOWN;
                    dir_d   = DIR_DOWN;
                end
            end
            MOVE_UP: begin
                if (tick_i) begin
                    if (floor_q == TOP_FLOOR) begin
                        state_d = IDLE;
                    end else begin
                        nf      = floor_q + 1'b1;
                        floor_d = nf;
                        if (pend_nx[nf]) begin
                            state_d       = DOOR_OPEN;
                            pending_d[nf] = 1'b0;
                            tmr_load      = 1'b1;
                            arrived_d     = 1'b1;
                        end else if (!any_above(pend_nx, nf)) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            MOVE_DOWN: begin
                if (tick_i) begin
                    if (floor_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        nf      = floor_q - 1'b1;
                        floor_d = nf;
                        if (pend_nx[nf]) begin
                            state_d       = DOOR_OPEN;
                            pending_d[nf] = 1'b0;
                            tmr_load      = 1'b1;
                            arrived_d     = 1'b1;
                        end else if (!any_below(pend_nx, nf)) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DOOR_OPEN: begin
                // A call at the open floor holds the door rather than queueing.
                if (pend_nx[floor_q]) begin
                    pending_d[floor_q] = 1'b0;
                    tmr_load           = 1'b1;
                end else if (tmr_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef ELEVATOR_ESTOP_EN
        if (estop_i) begin
            state_d   = state_q;
            dir_d     = dir_q;
            floor_d   = floor_q;
            pending_d = pend_nx;
            tmr_load  = 1'b0;
            tmr_tick  = 1'b0;
            arrived_d = 1'b0;
        end
        up_d = (state_d == MOVE_UP) && !estop_i;
        dn_d = (state_d == MOVE_DOWN) && !estop_i;
`else
        up_d = (state_d == MOVE_UP);
        dn_d = (state_d == MOVE_DOWN);
`endif
        door_d = (state_d == DOOR_OPEN);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            floor_q   <= '0;
            pending_q <= '0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            door_q    <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            door_q    <= door_d;
            arrived_q <= arrived_d;
        end
    end

    assign floor_o       = floor_q;
    assign moving_up_o   = up_q;
    assign moving_down_o = dn_q;
    assign door_open_o   = door_q;
    assign pending_o     = pending_q;
    assign arrived_o     = arrived_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl (8 floors, 3 door ticks, tick every 4 cycles).
module tb_elevator_car_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] req = 8'h00;
`ifdef ELEVATOR_ESTOP_EN
    logic       estop = 1'b0;
`endif
    logic [2:0] floor;
    logic       up, dn, door, arrived;
    logic [7:0] pending;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    elevator_car_ctrl #(.NUM_FLOORS(8), .DOOR_TICKS(3)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .tick_i        (tick),
        .req_i         (req),
`ifdef ELEVATOR_ESTOP_EN
        .estop_i       (estop),
`endif
        .floor_o       (floor),
        .moving_up_o   (up),
        .moving_down_o (dn),
        .door_open_o   (door),
        .pending_o     (pending),
        .arrived_o     (arrived)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("dir_exclusive", 32'(up & dn), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tick_edge();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic tick_period();
        idle(3);
        tick_edge();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_floor"}, 32'(floor), 32'd0);
        chk({tag, "_up"}, 32'(up), 32'd0);
        chk({tag, "_dn"}, 32'(dn), 32'd0);
        chk({tag, "_door"}, 32'(door), 32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_arrived"}, 32'(arrived), 32'd0);
    endtask

    initial begin
        // Reset, with inputs active to show they are ignored.
        idle(2);
        req  = 8'hFF;
        tick = 1'b1;
        step();
        check_all_zero("reset");
        reset = 1'b0;
        req   = 8'h00;
        tick  = 1'b0;
        step();
        chk("post_reset_pending", 32'(pending), 32'h00);

        // Call to floor 5 from floor 0.
        req = 8'h20;
        step();
        req = 8'h00;
        chk("f5_up_start", 32'(up), 32'd1);
        chk("f5_pending", 32'(pending), 32'h20);
        idle(2);
        chk("f5_no_tick_hold", 32'(floor), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick_period();
            chk("f5_floor_step", 32'(floor), 32'(i));
            chk("f5_moving_up", 32'(up), 32'd1);
        end
        tick_period();
        chk("f5_arrive_floor", 32'(floor), 32'd5);
        chk("f5_arrived", 32'(arrived), 32'd1);
        chk("f5_door", 32'(door), 32'd1);
        chk("f5_up_drop", 32'(up), 32'd0);
        chk("f5_pending_clr", 32'(pending), 32'h00);
        step();
        chk("f5_arrived_pulse", 32'(arrived), 32'd0);

        // Door hold: second door tick coincides with a floor-5 call.
        idle(2);
        tick_edge();
        chk("hold_tick1_door", 32'(door), 32'd1);
        idle(3);
        req = 8'h20;
        tick_edge();
        req = 8'h00;
        chk("hold_reload_door", 32'(door), 32'd1);
        chk("hold_pending", 32'(pending), 32'h00);
        tick_period();
        chk("hold_after1", 32'(door), 32'd1);
        tick_period();
        chk("hold_after2", 32'(door), 32'd1);
        tick_period();
        chk("hold_close", 32'(door), 32'd0);
        chk("hold_close_floor", 32'(floor), 32'd5);

        // Reset from idle at floor 5, then travel to 3 and queue {6,1}.
        reset = 1'b1;
        step();
        chk("reset_idle_floor", 32'(floor), 32'd0);
        reset = 1'b0;
        req = 8'h08;
        step();
        req = 8'h00;
        for (int i = 0; i < 3; i++) tick_period();
        chk("f3_arrive", 32'(floor), 32'd3);
        chk("f3_arrived", 32'(arrived), 32'd1);
        step();
        req = 8'h42;
        step();
        req = 8'h00;
        chk("f3_pending61", 32'(pending), 32'h42);
        chk("f3_door", 32'(door), 32'd1);
        step();
        for (int i = 0; i < 3; i++) tick_period();
        chk("f3_door_close", 32'(door), 32'd0);
        step();
        chk("f3_depart_up", 32'(up), 32'd1);
        chk("f3_depart_floor", 32'(floor), 32'd3);
        for (int i = 0; i < 3; i++) tick_period();
        chk("f6_first_floor", 32'(floor), 32'd6);
        chk("f6_arrived", 32'(arrived), 32'd1);
        chk("f6_pending", 32'(pending), 32'h02);
        for (int i = 0; i < 3; i++) tick_period();
        step();
        chk("rev_down", 32'(dn), 32'd1);
        chk("rev_not_up", 32'(up), 32'd0);
        for (int i = 0; i < 5; i++) tick_period();
        chk("f1_floor", 32'(floor), 32'd1);
        chk("f1_arrived", 32'(arrived), 32'd1);
        chk("f1_pending", 32'(pending), 32'h00);
        for (int i = 0; i < 3; i++) tick_period();

        // Call for 4 lands on the same tick that steps 3->4.
        req = 8'h80;
        step();
        req = 8'h00;
        chk("f4_up", 32'(up), 32'd1);
        tick_period();
        tick_period();
        chk("f4_at3", 32'(floor), 32'd3);
        idle(3);
        req = 8'h10;
        tick_edge();
        req = 8'h00;
        chk("f4_floor", 32'(floor), 32'd4);
        chk("f4_arrived", 32'(arrived), 32'd1);
        chk("f4_door", 32'(door), 32'd1);
        chk("f4_pending", 32'(pending), 32'h80);
        idle(3);
        chk("f4_no_overshoot", 32'(floor), 32'd4);

        // Reset mid-door, then reset mid-travel at floor 2.
        reset = 1'b1;
        step();
        check_all_zero("rst_door");
        reset = 1'b0;
        req = 8'h08;
        step();
        req = 8'h00;
        tick_period();
        tick_period();
        chk("f2_floor", 32'(floor), 32'd2);
        chk("f2_up", 32'(up), 32'd1);
        reset = 1'b1;
        step();
        check_all_zero("rst_move");
        reset = 1'b0;
        step();

`ifdef ELEVATOR_ESTOP_EN
        req = 8'h08;
        step();
        req = 8'h00;
        tick_period();
        estop = 1'b1;
        step();
        chk("estop_up_drop", 32'(up), 32'd0);
        for (int i = 0; i < 10; i++) tick_period();
        chk("estop_floor", 32'(floor), 32'd1);
        chk("estop_up", 32'(up), 32'd0);
        chk("estop_pending", 32'(pending), 32'h08);
        estop = 1'b0;
        step();
        chk("estop_resume_up", 32'(up), 32'd1);
        tick_period();
        tick_period();
        chk("estop_arrive_floor", 32'(floor), 32'd3);
        chk("estop_arrived", 32'(arrived), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
